// File: rtl/modrm_ea_decoder_pkg.sv
// Shared types and encodings for the ModRM / displacement decoder.
package modrm_ea_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MODRM   = 2'd1,
    DISP_LO = 2'd2,
    DISP_HI = 2'd3
  } state_e;

  localparam logic [1:0] MOD_NODISP = 2'b00;
  localparam logic [1:0] MOD_DISP8  = 2'b01;
  localparam logic [1:0] MOD_DISP16 = 2'b10;
  localparam logic [1:0] MOD_REG    = 2'b11;

  localparam logic [2:0] RM_DIRECT = 3'b110;

  localparam logic [1:0] SEG_SS = 2'b10;
  localparam logic [1:0] SEG_DS = 2'b11;

  function automatic logic disp_is_16(input logic [1:0] md, input logic [2:0] rm);
    return (md == MOD_DISP16) || ((md == MOD_NODISP) && (rm == RM_DIRECT));
  endfunction

  function automatic logic needs_disp(input logic [1:0] md, input logic [2:0] rm);
    return (md == MOD_DISP8) || disp_is_16(md, rm);
  endfunction

endpackage

// File: rtl/modrm_ea_decoder_calc.sv
// Combinational 16-bit-style effective address adder: base/index from rm plus displacement.
module modrm_ea_calc
  import modrm_ea_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [1:0]            mode,
  input  logic [2:0]            rm,
  input  logic [ADDR_WIDTH-1:0] disp,
  input  logic [ADDR_WIDTH-1:0] bx,
  input  logic [ADDR_WIDTH-1:0] bp,
  input  logic [ADDR_WIDTH-1:0] si,
  input  logic [ADDR_WIDTH-1:0] di,
  output logic [ADDR_WIDTH-1:0] effective_address,
  output logic                  uses_bp
);

  logic [ADDR_WIDTH-1:0] base;

  always_comb begin
    base    = '0;
    uses_bp = 1'b0;
    case (rm)
      3'b000: base = bx + si;
      3'b001: base = bx + di;
      3'b010: begin base = bp + si; uses_bp = 1'b1; end
      3'b011: begin base = bp + di; uses_bp = 1'b1; end
      3'b100: base = si;
      3'b101: base = di;
      // mod 00 with rm 110 is a direct address: no base at all.
      3'b110: begin
        if (mode != MOD_NODISP) begin
          base    = bp;
          uses_bp = 1'b1;
        end
      end
      default: base = bx;
    endcase
    if (mode == MOD_REG) begin
      effective_address = '0;
      uses_bp           = 1'b0;
    end else begin
      effective_address = base + disp;
    end
  end

endmodule

// File: rtl/modrm_ea_decoder.sv
// ModRM + displacement fetch FSM with registered EA results.
// Optional default_seg output enabled by defining MODRM_SEG_SELECT_EN.
module modrm_ea_decoder
  import modrm_ea_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  complete,
  output logic [2:0]            regnum,
  output logic [2:0]            rm_regnum,
  output logic                  rm_is_reg,
  output logic [ADDR_WIDTH-1:0] effective_address,
  output logic [ADDR_WIDTH-1:0] displacement,
  input  logic [ADDR_WIDTH-1:0] bx,
  input  logic [ADDR_WIDTH-1:0] bp,
  input  logic [ADDR_WIDTH-1:0] si,
  input  logic [ADDR_WIDTH-1:0] di,
  output logic                  fifo_rd_en,
  input  logic [7:0]            fifo_rd_data,
  input  logic                  fifo_empty
`ifdef MODRM_SEG_SELECT_EN
  ,
  output logic [1:0]            default_seg
`endif
);

  state_e                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [1:0]            mod_q, mod_d, cur_mod;
  logic [2:0]            rm_q, rm_d, cur_rm;
  logic [2:0]            reg_q, reg_d;
  logic [7:0]            disp_lo_q, disp_lo_d;
  logic                  complete_q, complete_d;
  logic                  rm_is_reg_q, rm_is_reg_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d, disp_q, disp_d;
  logic [ADDR_WIDTH-1:0] disp_full, calc_ea;
  logic                  calc_uses_bp, finish, fetch_next;
  logic signed [7:0]     d8;
  logic signed [15:0]    d16;
`ifdef MODRM_SEG_SELECT_EN
  logic [1:0]            seg_q, seg_d;
`else
  logic                  seg_unused;
  assign seg_unused = calc_uses_bp;
`endif

  assign d8  = fifo_rd_data;
  assign d16 = {fifo_rd_data, disp_lo_q};

  modrm_ea_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_calc (
    .mode              (cur_mod),
    .rm                (cur_rm),
    .disp              (disp_full),
    .bx                (bx),
    .bp                (bp),
    .si                (si),
    .di                (di),
    .effective_address (calc_ea),
    .uses_bp           (calc_uses_bp)
  );

  always_comb begin
    state_d     = state_q;
    mod_d       = mod_q;
    rm_d        = rm_q;
    reg_d       = reg_q;
    disp_lo_d   = disp_lo_q;
    complete_d  = 1'b0;
    rm_is_reg_d = rm_is_reg_q;
    ea_d        = ea_q;
    disp_d      = disp_q;
`ifdef MODRM_SEG_SELECT_EN
    seg_d       = seg_q;
`endif
    cur_mod     = mod_q;
    cur_rm      = rm_q;
    disp_full   = '0;
    finish      = 1'b0;
    fetch_next  = 1'b0;
    // pending_q means the byte popped last cycle is on fifo_rd_data now.
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = MODRM;
          mod_d       = '0;
          rm_d        = '0;
          reg_d       = '0;
          disp_lo_d   = '0;
          rm_is_reg_d = 1'b0;
          ea_d        = '0;
          disp_d      = '0;
`ifdef MODRM_SEG_SELECT_EN
          seg_d       = SEG_DS;
`endif
        end
      end
      MODRM: begin
        if (pending_q) begin
          cur_mod     = fifo_rd_data[7:6];
          cur_rm      = fifo_rd_data[2:0];
          mod_d       = fifo_rd_data[7:6];
          rm_d        = fifo_rd_data[2:0];
          reg_d       = fifo_rd_data[5:3];
          rm_is_reg_d = (fifo_rd_data[7:6] == MOD_REG);
          if (needs_disp(fifo_rd_data[7:6], fifo_rd_data[2:0])) begin
            state_d    = DISP_LO;
            fetch_next = 1'b1;
          end else begin
            state_d = IDLE;
            finish  = 1'b1;
          end
        end
      end
      DISP_LO: begin
        if (pending_q) begin
          disp_lo_d = fifo_rd_data;
          if (disp_is_16(mod_q, rm_q)) begin
            state_d    = DISP_HI;
            fetch_next = 1'b1;
          end else begin
            state_d   = IDLE;
            finish    = 1'b1;
            disp_full = ADDR_WIDTH'(d8);
          end
        end
      end
      default: begin
        if (pending_q) begin
          state_d   = IDLE;
          finish    = 1'b1;
          disp_full = ADDR_WIDTH'(d16);
        end
      end
    endcase

    if (finish) begin
      complete_d = 1'b1;
      ea_d       = calc_ea;
      disp_d     = disp_full;
`ifdef MODRM_SEG_SELECT_EN
      seg_d      = calc_uses_bp ? SEG_SS : SEG_DS;
`endif
    end

    // Back-to-back pops: the next byte is requested while the current one lands.
    fifo_rd_en = ~fifo_empty & ~abort & ~reset & (state_q != IDLE)
               & (~pending_q | fetch_next);

    if (abort) begin
      state_d     = IDLE;
      complete_d  = 1'b0;
      mod_d       = mod_q;
      rm_d        = rm_q;
      reg_d       = reg_q;
      disp_lo_d   = disp_lo_q;
      rm_is_reg_d = rm_is_reg_q;
      ea_d        = ea_q;
      disp_d      = disp_q;
`ifdef MODRM_SEG_SELECT_EN
      seg_d       = seg_q;
`endif
    end
    pending_d = fifo_rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      mod_q       <= '0;
      rm_q        <= '0;
      reg_q       <= '0;
      disp_lo_q   <= '0;
      complete_q  <= 1'b0;
      rm_is_reg_q <= 1'b0;
      ea_q        <= '0;
      disp_q      <= '0;
`ifdef MODRM_SEG_SELECT_EN
      seg_q       <= SEG_DS;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mod_q       <= mod_d;
      rm_q        <= rm_d;
      reg_q       <= reg_d;
      disp_lo_q   <= disp_lo_d;
      complete_q  <= complete_d;
      rm_is_reg_q <= rm_is_reg_d;
      ea_q        <= ea_d;
      disp_q      <= disp_d;
`ifdef MODRM_SEG_SELECT_EN
      seg_q       <= seg_d;
`endif
    end
  end

  assign busy              = (state_q != IDLE);
  assign complete          = complete_q;
  assign regnum            = reg_q;
  assign rm_regnum         = rm_q;
  assign rm_is_reg         = rm_is_reg_q;
  assign effective_address = ea_q;
  assign displacement      = disp_q;
`ifdef MODRM_SEG_SELECT_EN
  assign default_seg       = seg_q;
`endif

endmodule
